// File: rtl/fetch_sequencer.sv
// fetch_sequencer: PC / IF-ID / ID-EX sequencing with redirect, stall, hazard and fetch-wait arbitration.
// Optional performance counters are built only when PERF_CNT_EN is defined.
module fetch_sequencer #(
  parameter int BOOT_DELAY = 2,
  parameter int CNT_W      = 32
) (
  input  logic             clk_i,
  input  logic             rst_n_i,
  input  logic             redirect_i,
  input  logic [31:0]      redirect_pc_i,
  input  logic             load_use_i,
  input  logic             dmem_busy_i,
  input  logic             imem_ack_i,
  output logic             imem_req_o,
  output logic             pc_back_o,
  output logic             pc_keep_o,
  output logic [31:0]      npc_o,
  output logic             ifid_keep_o,
  output logic             ifid_flush_o,
  output logic             idex_keep_o,
  output logic             idex_flush_o,
  output logic [CNT_W-1:0] stall_cnt_o,
  output logic [CNT_W-1:0] flush_cnt_o
);
  localparam int BW = $clog2(BOOT_DELAY + 1);
  typedef enum logic [1:0] {BOOT, RUN, WAIT_REDIR} state_e;
  state_e      state_q, state_d;
  logic [BW-1:0] boot_q, boot_d;
  logic [31:0] pend_q, pend_d;
  always_comb begin
    state_d      = state_q;
    boot_d       = boot_q;
    pend_d       = pend_q;
    imem_req_o   = 1'b0;
    pc_back_o    = 1'b0;
    pc_keep_o    = 1'b0;
    npc_o        = '0;
    ifid_keep_o  = 1'b0;
    ifid_flush_o = 1'b0;
    idex_keep_o  = 1'b0;
    idex_flush_o = 1'b0;
    if (state_q == BOOT) begin
      pc_keep_o    = 1'b1;
      ifid_flush_o = 1'b1;
      idex_flush_o = 1'b1;
      boot_d       = boot_q + BW'(1);
      if (boot_q == BW'(BOOT_DELAY - 1)) state_d = RUN;
    end else if (dmem_busy_i) begin
      imem_req_o  = 1'b1;
      pc_keep_o   = 1'b1;
      ifid_keep_o = 1'b1;
      idex_keep_o = 1'b1;
    end else if (state_q == RUN) begin
      imem_req_o = 1'b1;
      if (redirect_i) begin
        ifid_flush_o = 1'b1;
        idex_flush_o = 1'b1;
        pc_back_o    = imem_ack_i;
        pc_keep_o    = !imem_ack_i;
        npc_o        = imem_ack_i ? redirect_pc_i : '0;
        if (!imem_ack_i) begin
          pend_d  = redirect_pc_i;
          state_d = WAIT_REDIR;
        end
      end else if (load_use_i) begin
        pc_keep_o    = 1'b1;
        ifid_keep_o  = 1'b1;
        idex_flush_o = 1'b1;
      end else if (!imem_ack_i) begin
        pc_keep_o    = 1'b1;
        ifid_flush_o = 1'b1;
      end
    end else begin
      // the outstanding fetch must complete; its word is dropped on ack
      imem_req_o   = 1'b1;
      ifid_flush_o = 1'b1;
      pc_keep_o    = !imem_ack_i;
      pc_back_o    = imem_ack_i;
      npc_o        = !imem_ack_i ? '0 : redirect_i ? redirect_pc_i : pend_q;
      if (!imem_ack_i && redirect_i) pend_d = redirect_pc_i;
      if (imem_ack_i) state_d = RUN;
    end
  end
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q <= BOOT;
      boot_q  <= '0;
      pend_q  <= '0;
    end else begin
      state_q <= state_d;
      boot_q  <= boot_d;
      pend_q  <= pend_d;
    end
  end
`ifdef PERF_CNT_EN
  logic [CNT_W-1:0] stall_q, flush_q;
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      stall_q <= '0;
      flush_q <= '0;
    end else begin
      if (state_q != BOOT && pc_keep_o && !(&stall_q)) stall_q <= stall_q + CNT_W'(1);
      if (pc_back_o && !(&flush_q)) flush_q <= flush_q + CNT_W'(1);
    end
  end
  assign stall_cnt_o = stall_q;
  assign flush_cnt_o = flush_q;
`else
  assign stall_cnt_o = '0;
  assign flush_cnt_o = '0;
`endif
endmodule

// File: tb/tb_fetch_sequencer.sv
// tb_fetch_sequencer: directed and random stimulus checked against a priority-rule reference model.
module tb_fetch_sequencer;
  localparam int BOOT_DELAY = 2;
  logic clk = 1'b0, rst_n = 1'b0;
  logic redirect = 1'b0, load_use = 1'b0, busy = 1'b0, ack = 1'b1;
  logic [31:0] rpc = '0;
  logic req, back, keep, ik, ifl, xk, xf;
  logic [31:0] npc, stall_cnt, flush_cnt;
  int errs = 0, checks = 0;
  int boot_left;
  bit waiting;
  logic [31:0] pend, m_stall, m_flush, s_npc;
  logic e_req, e_back, e_keep, e_ik, e_if, e_xk, e_xf;
  logic [31:0] e_npc;

  fetch_sequencer #(.BOOT_DELAY(BOOT_DELAY), .CNT_W(32)) dut (
    .clk_i(clk), .rst_n_i(rst_n), .redirect_i(redirect), .redirect_pc_i(rpc),
    .load_use_i(load_use), .dmem_busy_i(busy), .imem_ack_i(ack), .imem_req_o(req),
    .pc_back_o(back), .pc_keep_o(keep), .npc_o(npc), .ifid_keep_o(ik), .ifid_flush_o(ifl),
    .idex_keep_o(xk), .idex_flush_o(xf), .stall_cnt_o(stall_cnt), .flush_cnt_o(flush_cnt));

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errs++;
      $error("FAIL %s observed=%h expected=%h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic void model_reset();
    boot_left = BOOT_DELAY; waiting = 0; pend = '0; m_stall = '0; m_flush = '0;
  endfunction

  function automatic void model_eval();
    {e_req, e_back, e_keep, e_ik, e_if, e_xk, e_xf} = '0;
    e_npc = '0;
    if (!rst_n || boot_left > 0) begin
      e_keep = 1; e_if = 1; e_xf = 1;
    end else begin
      e_req = 1;
      if (busy) begin
        e_keep = 1; e_ik = 1; e_xk = 1;
      end else if (waiting) begin
        e_if = 1;
        if (ack) begin e_back = 1; e_npc = redirect ? rpc : pend; end
        else e_keep = 1;
      end else if (redirect) begin
        e_if = 1; e_xf = 1;
        if (ack) begin e_back = 1; e_npc = rpc; end
        else e_keep = 1;
      end else if (load_use) begin
        e_keep = 1; e_ik = 1; e_xf = 1;
      end else if (!ack) begin
        e_keep = 1; e_if = 1;
      end
    end
  endfunction

  function automatic void model_commit();
    if (!rst_n) begin model_reset(); return; end
    if (boot_left > 0) begin boot_left--; return; end
    if (e_keep && m_stall != 32'hFFFF_FFFF) m_stall = m_stall + 1;
    if (e_back && m_flush != 32'hFFFF_FFFF) m_flush = m_flush + 1;
    if (busy) return;
    if (waiting) begin
      if (ack) waiting = 0;
      else if (redirect) pend = rpc;
    end else if (redirect && !ack) begin
      waiting = 1; pend = rpc;
    end
  endfunction

  task automatic compare_all();
    model_eval();
    chk("imem_req", req, e_req);
    chk("pc_back", back, e_back);
    chk("pc_keep", keep, e_keep);
    chk("npc", npc, e_npc);
    chk("ifid_keep", ik, e_ik);
    chk("ifid_flush", ifl, e_if);
    chk("idex_keep", xk, e_xk);
    chk("idex_flush", xf, e_xf);
`ifdef PERF_CNT_EN
    chk("stall_cnt", stall_cnt, m_stall);
    chk("flush_cnt", flush_cnt, m_flush);
`else
    chk("stall_cnt", stall_cnt, 32'h0);
    chk("flush_cnt", flush_cnt, 32'h0);
`endif
  endtask

  task automatic cyc(input bit rd, input logic [31:0] pc, input bit lu, input bit bz,
                     input bit ak, input bit arst);
    redirect = rd; rpc = pc; load_use = lu; busy = bz; ack = ak;
    if (arst) begin
      #1 rst_n = 0;
      model_reset();
      #1 chk("arst_keep", keep, 1'b1);
      chk("arst_req", req, 1'b0);
      chk("arst_stall", stall_cnt, 32'h0);
    end
    @(negedge clk);
    compare_all();
    s_npc = npc;
    @(posedge clk);
    model_commit();
    #1;
    if (arst) rst_n = 1;
  endtask

  initial begin
    model_reset();
    cyc(0, 0, 0, 0, 1, 0);
    cyc(0, 0, 0, 0, 1, 0);
    rst_n = 1;
    cyc(0, 0, 0, 0, 1, 0);
    cyc(0, 0, 0, 0, 1, 0);
    cyc(0, 0, 0, 0, 1, 0);
    chk("boot_done_req", req, 1'b1);
    cyc(1, 32'h40, 0, 0, 1, 0);
    chk("t2_npc", s_npc, 32'h40);
    cyc(0, 0, 0, 0, 1, 0);
    cyc(0, 0, 1, 0, 1, 0);
    cyc(0, 0, 0, 0, 1, 0);
    cyc(1, 32'h80, 0, 0, 0, 0);
    cyc(1, 32'h100, 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 1, 0);
    chk("t4_npc", s_npc, 32'h100);
    for (int i = 0; i < 4; i++) cyc(1, 32'h200, 0, 1, 1, 0);
    cyc(1, 32'h200, 0, 0, 1, 0);
    chk("t5_npc", s_npc, 32'h200);
    cyc(1, 32'h300, 1, 0, 0, 0);
    cyc(0, 0, 0, 1, 0, 0);
    cyc(0, 0, 0, 0, 0, 1);
    for (int i = 0; i < 600; i++)
      cyc($urandom_range(0, 3) == 0, $urandom & 32'hFFFF_FFFC, $urandom_range(0, 3) == 0,
          $urandom_range(0, 4) == 0, $urandom_range(0, 2) != 0, $urandom_range(0, 149) == 0);
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
